decode_ctrl_pipe: RTL and testbench
===================================

DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 Parameter ALUOP_W, default 3: width of the ALU-operation code (SHALL be >= 3).
REQ-002 Parameter BRANCH_FULL, default 1: 1 = BEQ/BNE/BLT/BGE/BLTU/BGEU legal; 0 = only BEQ/BNE legal.
REQ-003 Parameter LOAD_USE_DETECT, default 1: 1 = load-use stall logic present; 0 = id_stall tied 0.
REQ-004 Parameter CNT_W, default 8: width of the illegal-instruction counter.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 instr_valid  in  1  ID holds a valid instruction.
REQ-008 opcode / funct3  in  7 / 3  instruction fields.
REQ-009 rd / rs1 / rs2  in  5 / 5 / 5  register indices.
REQ-010 flush  in  1  branch/jump redirect; kill the ID instruction.
REQ-011 id_stall  out  1  hold PC and IF/ID this cycle.
REQ-012 ex_valid  out  1  EX-stage instruction valid.
REQ-013 ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_jal, ex_jalr, ex_branch  out  1 each  registered control.
REQ-014 ex_br_type  out  3  branch funct3; ex_alu_op  out  ALUOP_W; ex_rd  out  5; ex_illegal  out  1.
REQ-015 illegal_cnt  out  CNT_W  saturating count of illegal instructions entering EX.

Function
REQ-016 Decode SHALL be combinational: R 0110011 -> reg_write, aluop 010; I 0010011 -> reg_write, alu_src, aluop 100; LOAD 0000011 -> mem_read, mem_to_reg, reg_write, alu_src, aluop 000; STORE 0100011 -> mem_write, alu_src, aluop 000; BRANCH 1100011 -> branch, aluop 001; JAL 1101111 -> jal, reg_write, aluop 011; JALR 1100111 -> jalr, reg_write, alu_src, aluop 011; LUI 0110111 -> reg_write, aluop 101; AUIPC 0010111 -> reg_write, alu_src, aluop 110.
REQ-017 ALU-op bits above bit 2 SHALL be 0.
REQ-018 Illegal: unlisted opcode; BRANCH funct3 010/011; BRANCH funct3 1xx when BRANCH_FULL=0. Illegal -> all controls 0, ex_illegal=1, ex_valid=1.
REQ-019 reg_write SHALL be forced 0 when rd==0.
REQ-020 uses_rs1 = R, I, LOAD, STORE, BRANCH, JALR; uses_rs2 = R, STORE, BRANCH.
REQ-021 id_stall = LOAD_USE_DETECT & instr_valid & ~flush & ex_valid & ex_mem_read & ex_rd!=0 & ((ex_rd==rs1 & uses_rs1) | (ex_rd==rs2 & uses_rs2)); combinational, same cycle.
REQ-022 Per rising edge, priority: flush -> bubble; else id_stall -> bubble; else ex_* <= decode, ex_valid <= instr_valid.
REQ-023 A bubble SHALL clear ex_valid, every control, ex_illegal, ex_br_type and ex_alu_op; ex_rd <= 0.
REQ-024 With instr_valid=0 and no flush/stall, controls SHALL load as 0.
REQ-025 A load-use stall SHALL last exactly one cycle; the held instruction enters EX on the next edge.
REQ-026 illegal_cnt SHALL increment by 1 on an edge where an illegal valid instruction loads into EX, and SHALL saturate at all-ones.
REQ-027 Latency: ID inputs -> ex_* outputs in exactly 1 cycle.

Reset
REQ-028 rst high SHALL immediately zero every ex_* output and illegal_cnt, with id_stall 0, independent of clk.
REQ-029 On rst deassertion, the first edge SHALL load normally; rst mid-stall SHALL discard the stall.

Structure
REQ-030 Opcode constants, ALU-op codes (000 add, 001 cmp, 010 R, 011 jump, 100 I, 101 LUI, 110 AUIPC) and branch funct3 codes SHALL reside in shared package rv_ctrl_pkg.
REQ-031 Combinational decode SHALL be sub-module ctrl_decode; hazard logic, pipeline register and counter remain in decode_ctrl_pipe.

Verification
REQ-032 LW rd=5, then ADD rs1=5 -> id_stall=1 one cycle, EX bubble (ex_valid=0), ADD in EX next cycle, aluop 010.
REQ-033 LW rd=0, then ADD rs1=0 -> no stall; LW ex_reg_write=0.
REQ-034 flush=1 together with a load-use hazard -> id_stall=0, EX bubble.
REQ-035 BRANCH funct3=100 with BRANCH_FULL=0 -> ex_illegal=1, illegal_cnt +1; with BRANCH_FULL=1 -> ex_branch=1, ex_br_type=100.
REQ-036 CNT_W=2, 5 illegal opcodes 0000000 -> illegal_cnt 1,2,3,3,3.
REQ-037 Assert rst between edges while ex_valid=1 -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared RV32 decode constants: opcodes, ALU-op codes, branch funct3 codes and
// the EX-stage control bundle carried by the ID/EX register.
package rv_ctrl_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_CMP   = 3'b001;
   localparam logic [2:0] ALU_RTYPE = 3'b010;
   localparam logic [2:0] ALU_JUMP  = 3'b011;
   localparam logic [2:0] ALU_ITYPE = 3'b100;
   localparam logic [2:0] ALU_LUI   = 3'b101;
   localparam logic [2:0] ALU_AUIPC = 3'b110;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   typedef struct packed {
      logic       mem_read;
      logic       mem_to_reg;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic       jal;
      logic       jalr;
      logic       branch;
      logic       illegal;
      logic [2:0] br_type;
      logic [2:0] alu_op;
      logic [4:0] rd;
   } ex_ctrl_t;

   // funct3 010/011 are never branches; the signed/unsigned compares are optional.
   function automatic logic br_legal(input logic [2:0] f3, input logic full);
      case (f3)
         BR_BEQ, BR_BNE:                   br_legal = 1'b1;
         BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: br_legal = full;
         default:                          br_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32 main decoder: control bits, ALU-op class, illegal flag and
// source-register usage for hazard detection.
module ctrl_decode
   import rv_ctrl_pkg::*;
#(
   parameter int BRANCH_FULL = 1
) (
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [4:0] rd,
   output logic       mem_read,
   output logic       mem_to_reg,
   output logic       mem_write,
   output logic       alu_src,
   output logic       reg_write,
   output logic       jal,
   output logic       jalr,
   output logic       branch,
   output logic       illegal,
   output logic [2:0] br_type,
   output logic [2:0] alu_op,
   output logic       uses_rs1,
   output logic       uses_rs2
);

   always_comb begin
      mem_read   = 1'b0;
      mem_to_reg = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      jal        = 1'b0;
      jalr       = 1'b0;
      branch     = 1'b0;
      illegal    = 1'b0;
      br_type    = 3'b000;
      alu_op     = ALU_ADD;
      uses_rs1   = 1'b0;
      uses_rs2   = 1'b0;
      case (opcode)
         OPC_R:      begin reg_write = 1'b1; alu_op = ALU_RTYPE;
                           uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OPC_I:      begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_ITYPE;
                           uses_rs1 = 1'b1; end
         OPC_LOAD:   begin mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1;
                           alu_src = 1'b1; alu_op = ALU_ADD; uses_rs1 = 1'b1; end
         OPC_STORE:  begin mem_write = 1'b1; alu_src = 1'b1; alu_op = ALU_ADD;
                           uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OPC_BRANCH: begin branch = 1'b1; alu_op = ALU_CMP; br_type = funct3;
                           uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                           illegal = !br_legal(funct3, BRANCH_FULL != 0); end
         OPC_JAL:    begin jal = 1'b1; reg_write = 1'b1; alu_op = ALU_JUMP; end
         OPC_JALR:   begin jalr = 1'b1; reg_write = 1'b1; alu_src = 1'b1;
                           alu_op = ALU_JUMP; uses_rs1 = 1'b1; end
         OPC_LUI:    begin reg_write = 1'b1; alu_op = ALU_LUI; end
         OPC_AUIPC:  begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_AUIPC; end
         default:    illegal = 1'b1;
      endcase
      // An illegal instruction travels as a pure marker; source usage still follows opcode.
      if (illegal) begin
         mem_read   = 1'b0;
         mem_to_reg = 1'b0;
         mem_write  = 1'b0;
         alu_src    = 1'b0;
         reg_write  = 1'b0;
         jal        = 1'b0;
         jalr       = 1'b0;
         branch     = 1'b0;
         br_type    = 3'b000;
         alu_op     = ALU_ADD;
      end
      if (rd == 5'd0) reg_write = 1'b0;
   end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// ID-stage control: decode, load-use stall, ID/EX control register with
// flush/stall bubbles, and a saturating illegal-instruction counter.
module decode_ctrl_pipe
   import rv_ctrl_pkg::*;
#(
   parameter int ALUOP_W         = 3,
   parameter int BRANCH_FULL     = 1,
   parameter int LOAD_USE_DETECT = 1,
   parameter int CNT_W           = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   input  logic [6:0]         opcode,
   input  logic [2:0]         funct3,
   input  logic [4:0]         rd,
   input  logic [4:0]         rs1,
   input  logic [4:0]         rs2,
   input  logic               flush,
   output logic               id_stall,
   output logic               ex_valid,
   output logic               ex_mem_read,
   output logic               ex_mem_to_reg,
   output logic               ex_mem_write,
   output logic               ex_alu_src,
   output logic               ex_reg_write,
   output logic               ex_jal,
   output logic               ex_jalr,
   output logic               ex_branch,
   output logic [2:0]         ex_br_type,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic [4:0]         ex_rd,
   output logic               ex_illegal,
   output logic [CNT_W-1:0]   illegal_cnt
);

   ex_ctrl_t ex_q, ex_d;
   logic     ex_vld_q;
   logic     uses_rs1, uses_rs2;
   logic     dec_mem_read, dec_mem_to_reg, dec_mem_write, dec_alu_src, dec_reg_write;
   logic     dec_jal, dec_jalr, dec_branch, dec_illegal;
   logic [2:0] dec_br_type, dec_alu_op;
   logic     bubble, load_illegal;

   ctrl_decode #(.BRANCH_FULL(BRANCH_FULL)) u_dec (
      .opcode     (opcode),
      .funct3     (funct3),
      .rd         (rd),
      .mem_read   (dec_mem_read),
      .mem_to_reg (dec_mem_to_reg),
      .mem_write  (dec_mem_write),
      .alu_src    (dec_alu_src),
      .reg_write  (dec_reg_write),
      .jal        (dec_jal),
      .jalr       (dec_jalr),
      .branch     (dec_branch),
      .illegal    (dec_illegal),
      .br_type    (dec_br_type),
      .alu_op     (dec_alu_op),
      .uses_rs1   (uses_rs1),
      .uses_rs2   (uses_rs2)
   );

   assign id_stall = (LOAD_USE_DETECT != 0) && instr_valid && !flush && ex_vld_q
                     && ex_q.mem_read && (ex_q.rd != 5'd0)
                     && (((ex_q.rd == rs1) && uses_rs1) || ((ex_q.rd == rs2) && uses_rs2));

   assign bubble       = flush || id_stall;
   assign load_illegal = !bubble && instr_valid && dec_illegal;

   always_comb begin
      ex_d = '0;
      if (instr_valid) begin
         ex_d.mem_read   = dec_mem_read;
         ex_d.mem_to_reg = dec_mem_to_reg;
         ex_d.mem_write  = dec_mem_write;
         ex_d.alu_src    = dec_alu_src;
         ex_d.reg_write  = dec_reg_write;
         ex_d.jal        = dec_jal;
         ex_d.jalr       = dec_jalr;
         ex_d.branch     = dec_branch;
         ex_d.illegal    = dec_illegal;
         ex_d.br_type    = dec_br_type;
         ex_d.alu_op     = dec_alu_op;
         ex_d.rd         = rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_vld_q <= 1'b0;
         ex_q     <= '0;
      end else if (bubble) begin
         ex_vld_q <= 1'b0;
         ex_q     <= '0;
      end else begin
         ex_vld_q <= instr_valid;
         ex_q     <= ex_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         illegal_cnt <= '0;
      else if (load_illegal && (illegal_cnt != {CNT_W{1'b1}}))
         illegal_cnt <= illegal_cnt + 1'b1;
   end

   assign ex_valid      = ex_vld_q;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_to_reg = ex_q.mem_to_reg;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_alu_src    = ex_q.alu_src;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_jal        = ex_q.jal;
   assign ex_jalr       = ex_q.jalr;
   assign ex_branch     = ex_q.branch;
   assign ex_br_type    = ex_q.br_type;
   assign ex_alu_op     = ALUOP_W'(ex_q.alu_op);
   assign ex_rd         = ex_q.rd;
   assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench: default-parameter DUT alongside a reduced variant
// (BRANCH_FULL=0, no load-use detect, 2-bit counter, 4-bit ALU op) on shared stimulus.
module tb_decode_ctrl_pipe;
   import rv_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       instr_valid = 1'b0;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
   logic       flush = 1'b0;

   logic       id_stall, ex_valid, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src;
   logic       ex_reg_write, ex_jal, ex_jalr, ex_branch, ex_illegal;
   logic [2:0] ex_br_type, ex_alu_op;
   logic [4:0] ex_rd;
   logic [7:0] illegal_cnt;

   logic       b_stall, b_valid, b_mr, b_mtr, b_mw, b_as, b_rw, b_jal, b_jalr, b_br, b_ill;
   logic [2:0] b_br_type;
   logic [3:0] b_alu_op;
   logic [4:0] b_rd;
   logic [1:0] b_cnt;

   int n_vec = 0;
   int n_err = 0;

   wire [7:0] ctl   = {ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
                       ex_reg_write, ex_jal, ex_jalr, ex_branch};
   wire [7:0] b_ctl = {b_mr, b_mtr, b_mw, b_as, b_rw, b_jal, b_jalr, b_br};

   always #5 clk = ~clk;

   decode_ctrl_pipe dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct3(funct3),
      .rd(rd), .rs1(rs1), .rs2(rs2), .flush(flush), .id_stall(id_stall),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
      .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_branch(ex_branch), .ex_br_type(ex_br_type),
      .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_illegal(ex_illegal), .illegal_cnt(illegal_cnt)
   );

   decode_ctrl_pipe #(.ALUOP_W(4), .BRANCH_FULL(0), .LOAD_USE_DETECT(0), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct3(funct3),
      .rd(rd), .rs1(rs1), .rs2(rs2), .flush(flush), .id_stall(b_stall),
      .ex_valid(b_valid), .ex_mem_read(b_mr), .ex_mem_to_reg(b_mtr),
      .ex_mem_write(b_mw), .ex_alu_src(b_as), .ex_reg_write(b_rw),
      .ex_jal(b_jal), .ex_jalr(b_jalr), .ex_branch(b_br), .ex_br_type(b_br_type),
      .ex_alu_op(b_alu_op), .ex_rd(b_rd), .ex_illegal(b_ill), .illegal_cnt(b_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
      instr_valid = v; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic [7:0] ctl;
      logic [2:0] alu;
      logic       ill;
   } vec_t;
   vec_t tbl[7];

   initial begin
      tbl[0] = '{OPC_I,      3'b000, 8'b00011000, 3'd4, 1'b0};
      tbl[1] = '{OPC_STORE,  3'b010, 8'b00110000, 3'd0, 1'b0};
      tbl[2] = '{OPC_JAL,    3'b000, 8'b00001100, 3'd3, 1'b0};
      tbl[3] = '{OPC_JALR,   3'b000, 8'b00011010, 3'd3, 1'b0};
      tbl[4] = '{OPC_LUI,    3'b000, 8'b00001000, 3'd5, 1'b0};
      tbl[5] = '{OPC_AUIPC,  3'b000, 8'b00011000, 3'd6, 1'b0};
      tbl[6] = '{OPC_BRANCH, 3'b010, 8'b00000000, 3'd0, 1'b1};

      // reset state
      #1;
      check("rst_valid", ex_valid, 0);
      check("rst_ctl", ctl, 0);
      check("rst_cnt", illegal_cnt, 0);
      check("rst_stall", id_stall, 0);
      #11 rst = 1'b0;

      // load-use: LW x5 then ADD using x5
      drive(1, OPC_LOAD, 3'b010, 5'd5, 5'd1, 5'd0);
      step();
      check("lw_valid", ex_valid, 1);
      check("lw_ctl", ctl, 8'b11011000);
      check("lw_rd", ex_rd, 5);
      drive(1, OPC_R, 3'b000, 5'd6, 5'd5, 5'd2);
      #1 check("lu_stall", id_stall, 1);
      check("lu_stall_b", b_stall, 0);
      step();
      check("lu_bubble_valid", ex_valid, 0);
      check("lu_bubble_rd", ex_rd, 0);
      check("lu_released", id_stall, 0);
      step();
      check("add_valid", ex_valid, 1);
      check("add_aluop", ex_alu_op, 3'b010);
      check("add_rd", ex_rd, 6);
      check("add_aluop_b", b_alu_op, 4'b0010);

      // rd=0 load never stalls and never writes
      drive(1, OPC_LOAD, 3'b010, 5'd0, 5'd1, 5'd0);
      step();
      check("lw0_rw", ex_reg_write, 0);
      check("lw0_mr", ex_mem_read, 1);
      drive(1, OPC_R, 3'b000, 5'd7, 5'd0, 5'd0);
      #1 check("lw0_stall", id_stall, 0);
      step();
      check("add0_valid", ex_valid, 1);

      // flush wins over a load-use hazard
      drive(1, OPC_LOAD, 3'b010, 5'd5, 5'd1, 5'd0);
      step();
      drive(1, OPC_R, 3'b000, 5'd6, 5'd5, 5'd2);
      flush = 1'b1;
      #1 check("fl_stall", id_stall, 0);
      step();
      check("fl_valid", ex_valid, 0);
      check("fl_ctl", ctl, 0);
      flush = 1'b0;

      // BLT: legal with full branches, illegal on the reduced variant
      drive(1, OPC_BRANCH, 3'b100, 5'd0, 5'd3, 5'd4);
      step();
      check("blt_br", ex_branch, 1);
      check("blt_type", ex_br_type, 3'b100);
      check("blt_ill", ex_illegal, 0);
      check("blt_cnt", illegal_cnt, 0);
      check("blt_b_ill", b_ill, 1);
      check("blt_b_valid", b_valid, 1);
      check("blt_b_ctl", b_ctl, 0);
      check("blt_b_cnt", b_cnt, 1);

      // async reset between edges while EX holds a valid instruction
      drive(1, 7'b0000000, 3'b000, 5'd1, 5'd0, 5'd0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", ex_valid, 0);
      check("mid_rst_br", ex_branch, 0);
      check("mid_rst_b_cnt", b_cnt, 0);
      check("mid_rst_b_valid", b_valid, 0);
      #1 rst = 1'b0;

      // illegal opcode stream: 2-bit counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("ill%0d_flag", i), ex_illegal, 1);
         check($sformatf("ill%0d_valid", i), ex_valid, 1);
         check($sformatf("ill%0d_cnt", i), illegal_cnt, i + 1);
         check($sformatf("ill%0d_b_cnt", i), b_cnt, (i < 3) ? i + 1 : 3);
      end

      // remaining opcode classes
      for (int i = 0; i < 7; i++) begin
         drive(1, tbl[i].op, tbl[i].f3, 5'd1, 5'd0, 5'd0);
         step();
         check($sformatf("tbl%0d_ctl", i), ctl, tbl[i].ctl);
         check($sformatf("tbl%0d_alu", i), ex_alu_op, tbl[i].alu);
         check($sformatf("tbl%0d_ill", i), ex_illegal, tbl[i].ill);
      end
      check("end_cnt", illegal_cnt, 6);
      check("end_b_cnt", b_cnt, 3);

      // no valid instruction loads zeros
      drive(0, OPC_R, 3'b000, 5'd9, 5'd0, 5'd0);
      step();
      check("idle_valid", ex_valid, 0);
      check("idle_ctl", ctl, 0);
      check("idle_rd", ex_rd, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
